// File: rtl/mem_stage.sv
// mem_stage: byte-serial memory access stage between execute and writeback.
// Loads and stores move one byte per cycle over an 8-bit RAM port,
// little-endian, with the pipeline held by stall_req while busy.
// Optional build macro: MEM_STAGE_MISALIGN_CHECK_EN rejects word accesses
// whose address is not 4-byte aligned and raises a one-cycle misalign flag.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wa_i,
    input  logic        we_i,
    input  logic [31:0] wn_i,
    input  logic [3:0]  ex_mem_e,
    input  logic [31:0] ex_mem_n,
    output logic [4:0]  wa_o,
    output logic        we_o,
    output logic [31:0] wn_o,
    output logic        stall_req,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // captured request: base address, store data / load assembly, writeback tag
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  wa_tag_q, wa_tag_d;
    logic        we_tag_q, we_tag_d;
    logic        len_q, len_d;
    logic        store_q, store_d;
    logic        unsigned_q, unsigned_d;

    // registered outputs
    logic [4:0]  wa_o_q, wa_o_d;
    logic        we_o_q, we_o_d;
    logic [31:0] wn_o_q, wn_o_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic        err_q, err_d;
    logic        misalign_q, misalign_d;
`endif

    logic [2:0]  n_bytes;
    logic [2:0]  next_idx;
    logic [31:0] next_addr;
    logic [7:0]  next_store_byte;
    logic [31:0] load_value;
    logic        req_misaligned;

    // Helpers: access length, next byte index/address and the store byte for it
    always_comb begin
        n_bytes   = len_q ? 3'd4 : 3'd1;
        next_idx  = cnt_q + 3'd1;
        next_addr = addr_q + {29'd0, next_idx};
        case (next_idx)
            3'd1:    next_store_byte = data_q[15:8];
            3'd2:    next_store_byte = data_q[23:16];
            3'd3:    next_store_byte = data_q[31:24];
            default: next_store_byte = data_q[7:0];
        endcase
    end

    // Final load result: words as assembled, bytes sign- or zero-extended
    always_comb begin
        if (len_q) begin
            load_value = data_q;
        end else if (unsigned_q) begin
            load_value = {24'd0, data_q[7:0]};
        end else begin
            load_value = {{24{data_q[7]}}, data_q[7:0]};
        end
    end

    // Misalignment is only flagged when the check is built in
    always_comb begin
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        req_misaligned = ex_mem_e[1] && (wn_i[1:0] != 2'b00);
`else
        req_misaligned = 1'b0;
`endif
    end

    // Next-state and output logic of the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wa_tag_d    = wa_tag_q;
        we_tag_d    = we_tag_q;
        len_d       = len_q;
        store_d     = store_q;
        unsigned_d  = unsigned_q;
        wa_o_d      = wa_o_q;
        we_o_d      = we_o_q;
        wn_o_d      = wn_o_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        stall_req   = 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        err_d       = err_q;
        misalign_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!ex_mem_e[0]) begin
                    wa_o_d = wa_i;
                    we_o_d = we_i;
                    wn_o_d = wn_i;
                end else begin
                    stall_req  = 1'b1;
                    we_o_d     = 1'b0;
                    cnt_d      = 3'd0;
                    addr_d     = wn_i;
                    wa_tag_d   = wa_i;
                    we_tag_d   = we_i;
                    len_d      = ex_mem_e[1];
                    store_d    = ex_mem_e[2];
                    unsigned_d = ex_mem_e[3];
                    if (req_misaligned) begin
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
                        err_d   = 1'b1;
`endif
                        state_d = FIN;
                    end else if (ex_mem_e[2]) begin
                        data_d     = ex_mem_n;
                        mem_a_d    = wn_i;
                        mem_dout_d = ex_mem_n[7:0];
                        mem_wr_d   = 1'b1;
                        state_d    = STORE;
                    end else begin
                        data_d  = 32'd0;
                        mem_a_d = wn_i;
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                stall_req = 1'b1;
                // byte (cnt-1) was addressed last cycle and is on mem_din now
                case (cnt_q)
                    3'd1:    data_d[7:0]   = mem_din;
                    3'd2:    data_d[15:8]  = mem_din;
                    3'd3:    data_d[23:16] = mem_din;
                    3'd4:    data_d[31:24] = mem_din;
                    default: ;
                endcase
                if (cnt_q == n_bytes) begin
                    cnt_d   = 3'd0;
                    state_d = FIN;
                end else begin
                    cnt_d = next_idx;
                    if (next_idx < n_bytes) begin
                        mem_a_d = next_addr;
                    end
                end
            end

            STORE: begin
                stall_req = 1'b1;
                if (next_idx < n_bytes) begin
                    cnt_d      = next_idx;
                    mem_a_d    = next_addr;
                    mem_dout_d = next_store_byte;
                    mem_wr_d   = 1'b1;
                end else begin
                    cnt_d   = 3'd0;
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
                wa_o_d  = wa_tag_q;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
                if (err_q) begin
                    we_o_d     = 1'b0;
                    wn_o_d     = 32'd0;
                    misalign_d = 1'b1;
                    err_d      = 1'b0;
                end else
`endif
                if (store_q) begin
                    we_o_d = 1'b0;
                    wn_o_d = 32'd0;
                end else begin
                    we_o_d = we_tag_q;
                    wn_o_d = load_value;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wa_tag_q   <= 5'd0;
            we_tag_q   <= 1'b0;
            len_q      <= 1'b0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wa_o_q     <= 5'd0;
            we_o_q     <= 1'b0;
            wn_o_q     <= 32'd0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wa_tag_q   <= wa_tag_d;
            we_tag_q   <= we_tag_d;
            len_q      <= len_d;
            store_q    <= store_d;
            unsigned_q <= unsigned_d;
            wa_o_q     <= wa_o_d;
            we_o_q     <= we_o_d;
            wn_o_q     <= wn_o_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
            err_q      <= err_d;
            misalign_q <= misalign_d;
`endif
        end
    end

    assign wa_o     = wa_o_q;
    assign we_o     = we_o_q;
    assign wn_o     = wn_o_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule
